sme_job_ctrl: RTL and testbench
===============================

# sme_job_ctrl

Job controller that sequences the string-matching engine. A host loads one string and up to NPAT patterns into local buffers, then pulses `start`. The controller replays the string followed by each pattern to the engine, waits for the engine's `valid`, and returns one result per pattern over a valid/ready port. It sits between the host byte interface and the SME datapath, and is the only driver of the engine's `chardata`/`isstring`/`ispattern`.

## Interface
- STR_MAX, 32: string buffer depth in bytes.
- PAT_MAX, 8: maximum bytes per pattern.
- NPAT, 4: pattern slots; PW = clog2(NPAT).
- TIMEOUT, 255: WAIT-state watchdog limit in cycles (8-bit counter).

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- chardata  in  8  host byte.
- ld_str  in  1  append `chardata` to the string buffer.
- ld_pat  in  1  append `chardata` to the current pattern.
- pat_end  in  1  qualifies `ld_pat`; this byte closes the pattern.
- start  in  1  begin a run.
- busy  out  1  run in progress.
- ovf  out  1  sticky; set when a load is dropped; cleared by reset or `start`.
- done  out  1  one-cycle pulse at end of run.
- eng_chardata  out  8  byte to the engine.
- eng_isstring  out  1  string strobe.
- eng_ispattern  out  1  pattern strobe.
- eng_valid  in  1  engine result strobe.
- eng_match  in  1  engine match bit.
- eng_match_index  in  5  engine match position.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_match  out  1  match bit of the result.
- res_index  out  5  match index of the result.
- res_pat_id  out  PW  pattern slot number of the result.
- res_timeout  out  1  result was produced by the watchdog.

## Operation
- States: IDLE, SEND_STR, SEND_PAT, WAIT, PUSH, DONE.
- Loading (IDLE only):
  - When both `ld_str` and `ld_pat` are high, `ld_str` wins and `ld_pat` is ignored.
  - A string byte is dropped when `str_len == STR_MAX`; the drop sets `ovf`.
  - A pattern byte is dropped when the open pattern already holds PAT_MAX bytes, or when `pat_cnt == NPAT`; either drop sets `ovf`.
  - If `pat_end` arrives on a dropped byte, the pattern still closes.
  - A closed pattern with zero stored bytes still counts as a pattern.
  - A pattern still open at `start` is discarded.
- `start` in IDLE:
  - If `str_len == 0` or `pat_cnt == 0`: go to DONE, with no engine strobes.
  - Otherwise: set `busy`, set `job = 0`, go to SEND_STR.
  - `start` outside IDLE is ignored.
  - Loads in the same cycle as `start` are accepted and used by the run.
- SEND_STR: drive `eng_isstring = 1` and `eng_chardata = str[k]` for k = 0..str_len-1, one byte per cycle, then go to SEND_PAT.
- SEND_PAT: drive `eng_ispattern = 1` with `pat[job][k]` for k = 0..len-1, then go to WAIT. A zero-length pattern goes straight to WAIT.
- WAIT:
  - On `eng_valid`: capture `eng_match`/`eng_match_index`, set `res_timeout = 0`, go to PUSH.
  - When the watchdog reaches TIMEOUT cycles: set `res_match = 0`, `res_index = 0`, `res_timeout = 1`, go to PUSH.
  - `eng_valid` in any other state is ignored.
- PUSH:
  - Hold `res_valid = 1` until `res_ready` is high at an edge.
  - After acceptance: if `job == pat_cnt-1` go to DONE; otherwise increment `job` and go to SEND_STR. The string is resent for every job.
- DONE: `done = 1` for one cycle, `busy = 0`. Clear `str_len`, `pat_cnt` and the open pattern length; return to IDLE.
- Loads during `busy` are ignored and do not set `ovf`.
- All engine and result outputs are registered. Engine strobes are 0 outside SEND_STR/SEND_PAT; `eng_chardata` is 0 when no strobe is active.

## Timing
- Reset values: `busy`, `ovf`, `done`, `eng_*` outputs, `res_valid`, `res_match`, `res_index`, `res_pat_id`, `res_timeout` all 0. State is IDLE, and counters and lengths are 0. Buffer contents need no reset.
- A reset mid-run forces all of the above at the next edge. The engine strobes drop immediately, and no `done` is produced.
- With `start` at edge T, string length L and pattern length P:
  - `eng_isstring` is high in cycles T+1..T+L.
  - `eng_ispattern` is high in T+L+1..T+L+P.
  - WAIT begins at T+L+P+1.
- `eng_valid` sampled at edge V gives `res_valid = 1` from V+1.
- Acceptance at edge A: `res_valid` is 0 from A+1, and the next job's first string byte is driven in A+1.
- The watchdog clears on WAIT entry. A timeout fires after TIMEOUT full WAIT cycles without `eng_valid`.
- `eng_valid` in the same cycle the watchdog expires counts as a real result.
- Back-to-back: `res_ready` held high gives one PUSH cycle per job.

## Test plan
- Load "hello world" (L=11) and pattern "wor"; start; engine model answers valid, match=1, index=6 -> strobes at T+1..T+14; result {match=1, index=6, pat_id=0, timeout=0}; `done` follows acceptance.
- Load 4 patterns with `res_ready` toggling 1/0 -> 4 results in order, pat_id 0..3, each held stable while not ready; the string is resent 4 times.
- Engine model never asserts valid, TIMEOUT=255 -> result at WAIT entry+255 with match=0, index=0, timeout=1.
- Overflow cases -> `ovf=1`, and exactly 32 string bytes and 8 pattern bytes are replayed:
  - 33 string bytes with a 9-byte pattern.
  - 5 patterns; slot 4 is dropped.
- `start` with L=0, and `start` with no patterns -> `done` at T+1, no engine strobes, no results.
- Reset asserted in SEND_PAT and in PUSH -> the next cycle has all outputs 0, and the next `start` runs normally from empty buffers.

Source files
------------

// File: rtl/sme_job_ctrl.sv
// Job controller for the string-matching engine: buffers one host string and up to
// NPAT patterns, replays string+pattern per job, collects one result per pattern.
// Results are held on a valid/ready port; the run stalls in PUSH until accepted.
module sme_job_ctrl #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int NPAT    = 4,
  parameter int TIMEOUT = 255,
  localparam int PW     = (NPAT > 1) ? $clog2(NPAT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    chardata,
  input  logic          ld_str,
  input  logic          ld_pat,
  input  logic          pat_end,
  input  logic          start,
  output logic          busy,
  output logic          ovf,
  output logic          done,
  output logic [7:0]    eng_chardata,
  output logic          eng_isstring,
  output logic          eng_ispattern,
  input  logic          eng_valid,
  input  logic          eng_match,
  input  logic [4:0]    eng_match_index,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_match,
  output logic [4:0]    res_index,
  output logic [PW-1:0] res_pat_id,
  output logic          res_timeout
);

  localparam int SW  = $clog2(STR_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int LW  = $clog2(PAT_MAX + 1);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int CW  = $clog2(NPAT + 1);
  localparam int KW  = (SW > LW) ? SW : LW;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_STR, S_SEND_PAT, S_WAIT, S_PUSH, S_DONE
  } state_t;

  state_t           state;
  logic [SW-1:0]    str_len;
  logic [CW-1:0]    pat_cnt;
  logic [LW-1:0]    cur_len;
  logic [PW-1:0]    job;
  logic [KW-1:0]    k;
  logic [7:0]       wd;

  logic [7:0]       str_mem [STR_MAX];
  logic [7:0]       pat_mem [NPAT][PAT_MAX];
  logic [LW-1:0]    pat_len [NPAT];

  logic             idle, str_acc, str_drop, pat_sel, slot_full, byte_full;
  logic             pat_acc, pat_drop, pat_close, last_job;
  logic [SW-1:0]    str_len_nx;
  logic [CW-1:0]    pat_cnt_nx;
  logic [7:0]       first_byte;
  logic [LW-1:0]    cur_plen;

  // Load qualification: string load has priority, full buffers drop the byte,
  // and a pat_end closes the pattern even when its byte is dropped.
  assign idle       = (state == S_IDLE);
  assign str_acc    = idle && ld_str && (str_len != SW'(STR_MAX));
  assign str_drop   = idle && ld_str && (str_len == SW'(STR_MAX));
  assign pat_sel    = idle && ld_pat && !ld_str;
  assign slot_full  = (pat_cnt == CW'(NPAT));
  assign byte_full  = (cur_len == LW'(PAT_MAX));
  assign pat_acc    = pat_sel && !slot_full && !byte_full;
  assign pat_drop   = pat_sel && (slot_full || byte_full);
  assign pat_close  = pat_sel && pat_end && !slot_full;
  assign str_len_nx = str_len + SW'(str_acc);
  assign pat_cnt_nx = pat_cnt + CW'(pat_close);
  // A string byte loaded on the start cycle into an empty buffer is bypassed.
  assign first_byte = (str_len == '0) ? chardata : str_mem[0];
  assign cur_plen   = pat_len[job];
  assign last_job   = ((CW'(job) + CW'(1)) == pat_cnt);

  // Buffer storage; contents are only read below the tracked lengths, so no reset.
  always_ff @(posedge clk) begin
    if (str_acc)   str_mem[str_len[SAW-1:0]] <= chardata;
    if (pat_acc)   pat_mem[pat_cnt[PW-1:0]][cur_len[PAW-1:0]] <= chardata;
    if (pat_close) pat_len[pat_cnt[PW-1:0]] <= cur_len + LW'(pat_acc);
  end

  // Run sequencer with registered engine/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      ovf           <= 1'b0;
      done          <= 1'b0;
      eng_chardata  <= '0;
      eng_isstring  <= 1'b0;
      eng_ispattern <= 1'b0;
      res_valid     <= 1'b0;
      res_match     <= 1'b0;
      res_index     <= '0;
      res_pat_id    <= '0;
      res_timeout   <= 1'b0;
      str_len       <= '0;
      pat_cnt       <= '0;
      cur_len       <= '0;
      job           <= '0;
      k             <= '0;
      wd            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ovf     <= (ovf && !start) || str_drop || pat_drop;
          str_len <= str_len_nx;
          pat_cnt <= pat_cnt_nx;
          cur_len <= pat_close ? '0 : cur_len + LW'(pat_acc);
          if (start) begin
            cur_len <= '0;
            if (str_len_nx == '0 || pat_cnt_nx == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy         <= 1'b1;
              job          <= '0;
              k            <= KW'(1);
              eng_isstring <= 1'b1;
              eng_chardata <= first_byte;
              state        <= S_SEND_STR;
            end
          end
        end
        S_SEND_STR: begin
          if (k < KW'(str_len)) begin
            eng_chardata <= str_mem[k[SAW-1:0]];
            k            <= k + KW'(1);
          end else if (cur_plen != '0) begin
            eng_isstring  <= 1'b0;
            eng_ispattern <= 1'b1;
            eng_chardata  <= pat_mem[job][0];
            k             <= KW'(1);
            state         <= S_SEND_PAT;
          end else begin
            eng_isstring <= 1'b0;
            eng_chardata <= '0;
            wd           <= '0;
            state        <= S_WAIT;
          end
        end
        S_SEND_PAT: begin
          if (k < KW'(cur_plen)) begin
            eng_chardata <= pat_mem[job][k[PAW-1:0]];
            k            <= k + KW'(1);
          end else begin
            eng_ispattern <= 1'b0;
            eng_chardata  <= '0;
            wd            <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A real result wins over a watchdog expiry in the same cycle.
          if (eng_valid) begin
            res_valid   <= 1'b1;
            res_match   <= eng_match;
            res_index   <= eng_match_index;
            res_pat_id  <= job;
            res_timeout <= 1'b0;
            state       <= S_PUSH;
          end else if (wd == 8'(TIMEOUT - 1)) begin
            res_valid   <= 1'b1;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_pat_id  <= job;
            res_timeout <= 1'b1;
            state       <= S_PUSH;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        S_PUSH: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_job) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              job          <= job + PW'(1);
              k            <= KW'(1);
              eng_isstring <= 1'b1;
              eng_chardata <= str_mem[0];
              state        <= S_SEND_STR;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          str_len <= '0;
          pat_cnt <= '0;
          cur_len <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_job_ctrl.sv
// Directed bench for sme_job_ctrl: replay timing, result handshake, watchdog,
// overflow, empty-run and mid-run reset behaviour.
module tb_sme_job_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       ld_str, ld_pat, pat_end, start;
  logic       busy, ovf, done;
  logic [7:0] eng_chardata;
  logic       eng_isstring, eng_ispattern;
  logic       eng_valid, eng_match;
  logic [4:0] eng_match_index;
  logic       res_valid, res_ready, res_match, res_timeout;
  logic [4:0] res_index;
  logic [1:0] res_pat_id;

  int n_chk = 0;
  int n_err = 0;

  sme_job_ctrl dut (
    .clk(clk), .reset(reset), .chardata(chardata), .ld_str(ld_str), .ld_pat(ld_pat),
    .pat_end(pat_end), .start(start), .busy(busy), .ovf(ovf), .done(done),
    .eng_chardata(eng_chardata), .eng_isstring(eng_isstring), .eng_ispattern(eng_ispattern),
    .eng_valid(eng_valid), .eng_match(eng_match), .eng_match_index(eng_match_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_index(res_index), .res_pat_id(res_pat_id), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are observed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, busy, ovf, done, eng_isstring, eng_ispattern, eng_chardata,
            res_valid, res_match, res_index, res_pat_id, res_timeout};
  endfunction

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      ld_str = 1'b1; chardata = s[i];
      tick();
    end
    ld_str = 1'b0; chardata = 8'd0;
  endtask

  task automatic load_pat(input string p);
    for (int i = 0; i < p.len(); i++) begin
      ld_pat = 1'b1; pat_end = (i == p.len() - 1); chardata = p[i];
      tick();
    end
    ld_pat = 1'b0; pat_end = 1'b0; chardata = 8'd0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the first strobe cycle; returns in the first WAIT cycle.
  task automatic expect_stream(input string s, input string p);
    for (int i = 0; i < s.len(); i++) begin
      chk("str_byte", {22'd0, eng_isstring, eng_ispattern, eng_chardata}, {22'd0, 2'b10, s[i]});
      tick();
    end
    for (int i = 0; i < p.len(); i++) begin
      chk("pat_byte", {22'd0, eng_isstring, eng_ispattern, eng_chardata}, {22'd0, 2'b01, p[i]});
      tick();
    end
    chk("wait_quiet", {22'd0, eng_isstring, eng_ispattern, eng_chardata}, 32'd0);
  endtask

  // One job: replay check, engine answer, result check and handshake.
  task automatic run_job(input string s, input string p, input logic m,
                         input logic [4:0] idx, input logic [1:0] id, input logic early);
    expect_stream(s, p);
    res_ready = early;
    eng_valid = 1'b1; eng_match = m; eng_match_index = idx;
    tick();
    eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = 5'd0;
    chk("res", {23'd0, res_valid, res_match, res_index, res_pat_id, res_timeout},
        {23'd0, 1'b1, m, idx, id, 1'b0});
    if (!early) begin
      tick();
      chk("res_hold", {23'd0, res_valid, res_match, res_index, res_pat_id, res_timeout},
          {23'd0, 1'b1, m, idx, id, 1'b0});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_drop", {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; chardata = 8'd0; ld_str = 1'b0; ld_pat = 1'b0; pat_end = 1'b0;
    start = 1'b0; eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = 5'd0;
    res_ready = 1'b0;
    tick(); tick();
    chk("reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();

    // Basic run: "hello world" / "wor", match at 6.
    load_str("hello world");
    load_pat("wor");
    chk("no_ovf", {31'd0, ovf}, 32'd0);
    do_start();
    chk("busy_set", {31'd0, busy}, 32'd1);
    run_job("hello world", "wor", 1'b1, 5'd6, 2'd0, 1'b0);
    chk("done_pulse", {30'd0, done, busy}, 32'd2);
    tick();
    chk("done_clear", {31'd0, done}, 32'd0);

    // Five patterns: slot 4 dropped, string resent per job, ready toggled/held.
    load_str("xyz");
    load_pat("ab"); load_pat("c"); load_pat("de"); load_pat("f"); load_pat("g");
    chk("ovf_slot", {31'd0, ovf}, 32'd1);
    do_start();
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    run_job("xyz", "ab", 1'b1, 5'd1, 2'd0, 1'b0);
    run_job("xyz", "c",  1'b0, 5'd2, 2'd1, 1'b1);
    run_job("xyz", "de", 1'b1, 5'd3, 2'd2, 1'b0);
    run_job("xyz", "f",  1'b0, 5'd4, 2'd3, 1'b1);
    chk("done_4jobs", {31'd0, done}, 32'd1);
    tick();

    // Watchdog: engine never answers.
    load_str("ab");
    load_pat("c");
    do_start();
    expect_stream("ab", "c");
    eng_match = 1'b1; eng_match_index = 5'd9;
    for (int i = 0; i < 254; i++) tick();
    chk("wd_early", {31'd0, res_valid}, 32'd0);
    tick();
    chk("wd_res", {23'd0, res_valid, res_match, res_index, res_pat_id, res_timeout},
        {23'd0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b1});
    eng_match = 1'b0; eng_match_index = 5'd0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("wd_done", {30'd0, done, res_valid}, 32'd2);
    tick();

    // String and pattern byte overflow.
    load_str("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefg");
    load_pat("012345678");
    chk("ovf_bytes", {31'd0, ovf}, 32'd1);
    do_start();
    run_job("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdef", "01234567", 1'b1, 5'd31, 2'd0, 1'b1);
    chk("ovf_run_done", {31'd0, done}, 32'd1);
    tick();

    // Empty string, then no patterns.
    load_pat("x");
    do_start();
    chk("empty_str", {29'd0, done, eng_isstring, eng_ispattern}, 32'd4);
    tick();
    chk("empty_str_idle", {30'd0, eng_isstring, res_valid}, 32'd0);
    load_str("abc");
    do_start();
    chk("no_pat", {28'd0, done, busy, eng_isstring, res_valid}, 32'd8);
    tick();

    // Reset during SEND_PAT.
    load_str("ab");
    load_pat("cd");
    do_start();
    tick(); tick();
    chk("in_pat", {30'd0, eng_isstring, eng_ispattern}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_pat_outs", all_outs(), 32'd0);
    load_str("km");
    load_pat("m");
    do_start();
    run_job("km", "m", 1'b1, 5'd1, 2'd0, 1'b0);
    chk("after_rst_done", {31'd0, done}, 32'd1);
    tick();

    // Reset during PUSH; buffers must be empty afterwards.
    load_str("ab");
    load_pat("c");
    do_start();
    expect_stream("ab", "c");
    eng_valid = 1'b1;
    tick();
    eng_valid = 1'b0;
    chk("in_push", {31'd0, res_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_push_outs", all_outs(), 32'd0);
    do_start();
    chk("rst_empty", {30'd0, done, eng_isstring}, 32'd2);
    tick();
    load_str("q");
    load_pat("r");
    do_start();
    run_job("q", "r", 1'b0, 5'd0, 2'd0, 1'b1);
    chk("final_done", {31'd0, done}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
